// File: rtl/dataslot_save_sequencer.sv
// Probes numbered APF save files until the bridge reports a freshly created one, then writes the
// save data into it, reporting the outcome through status/last_err and done/fail pulses.
module dataslot_save_sequencer #(
    parameter logic [15:0] SLOT_ID        = 16'd5,
    parameter int unsigned FIRST_INDEX    = 0,
    parameter int unsigned LAST_INDEX     = 99,
    parameter logic [31:0] PATH_ADDR      = 32'h3000_0000,
    parameter logic [31:0] DATA_ADDR      = 32'h2000_0000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] length_in,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  status,
    output logic [2:0]  last_err,
    output logic [7:0]  save_index,
    output logic        use_path,
    output logic        target_dataslot_openfile,
    output logic        target_dataslot_write,
    output logic [15:0] target_dataslot_id,
    output logic [31:0] target_dataslot_slotoffset,
    output logic [31:0] target_dataslot_bridgeaddr,
    output logic [31:0] target_dataslot_length,
    input  logic        target_dataslot_ack,
    input  logic        target_dataslot_done,
    input  logic [2:0]  target_dataslot_err
);

    localparam logic [7:0] FIRST_IDX   = 8'(FIRST_INDEX);
    localparam logic [7:0] LAST_IDX    = 8'(LAST_INDEX);
    localparam logic [2:0] ERR_CREATED = 3'd1;
    localparam logic       TIMEOUT_EN  = (TIMEOUT_CYCLES != '0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN_REQ,
        S_OPEN_WAIT,
        S_EVAL,
        S_WRITE_REQ,
        S_WRITE_WAIT,
        S_FINISH
    } state_e;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_NO_SLOT  = 3'd1,
        ST_ACK_TO   = 3'd2,
        ST_DONE_TO  = 3'd3,
        ST_WRITE_ER = 3'd4
    } status_e;

    state_e      state_q, state_d;
    status_e     status_q, status_d;
    logic [31:0] length_q, length_d;
    logic [7:0]  index_q, index_d;
    logic [2:0]  last_err_q, last_err_d;
    logic [23:0] timer_q, timer_d;
    logic        timeout_hit;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic        use_path_q, use_path_d;
    logic        openfile_q, openfile_d;
    logic        write_q, write_d;

    assign timeout_hit = TIMEOUT_EN && (timer_q == TIMEOUT_CYCLES - 24'd1);

    // State and datapath registers; reset returns everything to idle without a result pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            length_q   <= '0;
            index_q    <= FIRST_IDX;
            last_err_q <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            use_path_q <= 1'b0;
            openfile_q <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            length_q   <= length_d;
            index_q    <= index_d;
            last_err_q <= last_err_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            use_path_q <= use_path_d;
            openfile_q <= openfile_d;
            write_q    <= write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        length_d   = length_q;
        index_d    = index_q;
        last_err_d = last_err_q;
        timer_d    = timer_q + 24'd1;
        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (start) begin
                    length_d = length_in;
                    index_d  = FIRST_IDX;
                    status_d = ST_OK;
                    state_d  = S_OPEN_REQ;
                end
            end
            S_OPEN_REQ: begin
                if (target_dataslot_ack) begin
                    state_d = S_OPEN_WAIT;
                end else if (timeout_hit) begin
                    status_d = ST_ACK_TO;
                    state_d  = S_FINISH;
                end
            end
            S_OPEN_WAIT: begin
                if (target_dataslot_done) begin
                    last_err_d = target_dataslot_err;
                    state_d    = S_EVAL;
                end else if (timeout_hit) begin
                    status_d = ST_DONE_TO;
                    state_d  = S_FINISH;
                end
            end
            S_EVAL: begin
                if (last_err_q == ERR_CREATED) begin
                    state_d = S_WRITE_REQ;
                end else if (index_q == LAST_IDX) begin
                    status_d = ST_NO_SLOT;
                    state_d  = S_FINISH;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_OPEN_REQ;
                end
            end
            S_WRITE_REQ: begin
                if (target_dataslot_ack) begin
                    state_d = S_WRITE_WAIT;
                end else if (timeout_hit) begin
                    status_d = ST_ACK_TO;
                    state_d  = S_FINISH;
                end
            end
            S_WRITE_WAIT: begin
                if (target_dataslot_done) begin
                    last_err_d = target_dataslot_err;
                    status_d   = (target_dataslot_err == 3'd0) ? ST_OK : ST_WRITE_ER;
                    state_d    = S_FINISH;
                end else if (timeout_hit) begin
                    status_d = ST_DONE_TO;
                    state_d  = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // Outputs decode the next state so they can be registered without adding a cycle of lag.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        openfile_d = (state_d == S_OPEN_REQ);
        write_d    = (state_d == S_WRITE_REQ);
        use_path_d = (state_d == S_OPEN_REQ) || (state_d == S_OPEN_WAIT);
        done_d     = (state_d == S_FINISH) && (status_d == ST_OK);
        fail_d     = (state_d == S_FINISH) && (status_d != ST_OK);
    end

    assign busy                       = busy_q;
    assign done                       = done_q;
    assign fail                       = fail_q;
    assign status                     = status_q;
    assign last_err                   = last_err_q;
    assign save_index                 = index_q;
    assign use_path                   = use_path_q;
    assign target_dataslot_openfile   = openfile_q;
    assign target_dataslot_write      = write_q;
    assign target_dataslot_id         = SLOT_ID;
    assign target_dataslot_slotoffset = '0;
    assign target_dataslot_bridgeaddr = use_path_q ? PATH_ADDR : DATA_ADDR;
    assign target_dataslot_length     = length_q;

    a_result_excl: assert property (@(posedge clk) disable iff (!reset_n) !(done_q && fail_q));
    a_request_excl: assert property (@(posedge clk) disable iff (!reset_n) !(openfile_q && write_q));

endmodule
